// File: rtl/mem_req_initiator.sv
// mem_req_initiator: data-memory initiator for the Y86-64 memory stage.
// Decodes icode/valA/valE/valP on an accepted start and issues one valid/ready
// request to a multi-cycle memory. It then waits for the response and returns
// valM/mem_err with a one-cycle done pulse.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, icode, valA/E/P    operation launch and operands (sampled on start)
//   busy, done, valM, mem_err operation status and result
//   req_valid/ready/we/addr/wdata  request channel to memory
//   rsp_valid, rsp_rdata      response channel (write ack or read data)
module mem_req_initiator #(
   parameter logic [63:0] ADDR_LIMIT = 64'd1023,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  icode,
   input  logic [63:0] valA,
   input  logic [63:0] valE,
   input  logic [63:0] valP,
   output logic        busy,
   output logic        done,
   output logic [63:0] valM,
   output logic        mem_err,
   output logic        req_valid,
   input  logic        req_ready,
   output logic        req_we,
   output logic [63:0] req_addr,
   output logic [63:0] req_wdata,
   input  logic        rsp_valid,
   input  logic [63:0] rsp_rdata
);

   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   // Count value in the last REQ/WAIT cycle; the edge ending it moves to DONE.
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   logic        dec_acc;
   logic        dec_we;
   logic [63:0] dec_addr;
   logic [63:0] dec_data;

   // Memory-access decode of the incoming operation.
   always_comb begin
      dec_acc  = 1'b0;
      dec_we   = 1'b0;
      dec_addr = valE;
      dec_data = valA;
      case (icode)
         4'h4, 4'hA: begin dec_acc = 1'b1; dec_we = 1'b1; end
         4'h8:       begin dec_acc = 1'b1; dec_we = 1'b1; dec_data = valP; end
         4'h5:       dec_acc = 1'b1;
         4'h9, 4'hB: begin dec_acc = 1'b1; dec_addr = valA; end
         default:    dec_acc = 1'b0;
      endcase
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         valM      <= '0;
         mem_err   <= 1'b0;
         req_valid <= 1'b0;
         req_we    <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  cnt       <= '0;
                  busy      <= 1'b1;
                  req_we    <= dec_we;
                  req_addr  <= dec_addr;
                  req_wdata <= dec_data;
                  if (!dec_acc) begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     mem_err <= 1'b0;
                  end else if (dec_addr > ADDR_LIMIT) begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     mem_err <= 1'b1;
                  end else begin
                     state     <= S_REQ;
                     req_valid <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_TC) begin
                  state     <= S_DONE;
                  done      <= 1'b1;
                  mem_err   <= 1'b1;
                  req_valid <= 1'b0;
               end else if (req_ready) begin
                  state     <= S_WAIT;
                  req_valid <= 1'b0;
               end
            end
            S_WAIT: begin
               cnt <= cnt + CNT_W'(1);
               // A response in the terminal-count cycle still completes normally.
               if (rsp_valid) begin
                  state   <= S_DONE;
                  done    <= 1'b1;
                  mem_err <= 1'b0;
                  valM    <= req_we ? req_wdata : rsp_rdata;
               end else if (cnt == CNT_TC) begin
                  state   <= S_DONE;
                  done    <= 1'b1;
                  mem_err <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state     <= S_IDLE;
               busy      <= 1'b0;
               req_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed bench for mem_req_initiator (TIMEOUT=8, ADDR_LIMIT=1023).
module tb_mem_req_initiator;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  icode;
   logic [63:0] valA, valE, valP;
   logic        busy, done, mem_err;
   logic [63:0] valM;
   logic        req_valid, req_ready, req_we;
   logic [63:0] req_addr, req_wdata;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;

   int checks = 0;
   int errors = 0;
   int hs_cnt = 0;

   always #5 clk = ~clk;

   mem_req_initiator #(.ADDR_LIMIT(64'd1023), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .start(start), .icode(icode),
      .valA(valA), .valE(valE), .valP(valP),
      .busy(busy), .done(done), .valM(valM), .mem_err(mem_err),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
   );

   always @(posedge clk) if (req_valid && req_ready) hs_cnt <= hs_cnt + 1;

   typedef struct {
      logic [3:0]  icode;
      logic [63:0] valA, valE, valP, rdata;
      logic        exp_req;
      logic        exp_we;
      logic [63:0] exp_addr, exp_wdata;
      logic        exp_err;
      logic [63:0] exp_valM;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive start for one cycle; returns in the cycle after the accepting edge.
   task automatic launch(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                         input logic [63:0] p);
      @(negedge clk);
      icode = ic; valA = a; valE = e; valP = p; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // Scramble operands to confirm they were latched at the start edge.
      valA = ~a; valE = ~e; valP = ~p; icode = ~ic;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("v%0d", idx);
      rsp_rdata = v.rdata;
      launch(v.icode, v.valA, v.valE, v.valP);
      chk({tag, "_busy"}, 64'(busy), 64'(1));
      if (!v.exp_req) begin
         chk({tag, "_done_t1"}, 64'(done), 64'(1));
         chk({tag, "_noreq"}, 64'(req_valid), 64'(0));
      end else begin
         chk({tag, "_req_valid"}, 64'(req_valid), 64'(1));
         chk({tag, "_req_we"}, 64'(req_we), 64'(v.exp_we));
         chk({tag, "_req_addr"}, req_addr, v.exp_addr);
         if (v.exp_we) chk({tag, "_req_wdata"}, req_wdata, v.exp_wdata);
         req_ready = 1'b1;
         @(negedge clk);
         req_ready = 1'b0;
         chk({tag, "_req_drop"}, 64'(req_valid), 64'(0));
         chk({tag, "_done_early"}, 64'(done), 64'(0));
         rsp_valid = 1'b1;
         @(negedge clk);
         rsp_valid = 1'b0;
         chk({tag, "_done_t3"}, 64'(done), 64'(1));
      end
      chk({tag, "_err"}, 64'(mem_err), 64'(v.exp_err));
      chk({tag, "_valM"}, valM, v.exp_valM);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(done), 64'(0));
      chk({tag, "_idle"}, 64'(busy), 64'(0));
   endtask

   vec_t vecs[10];

   initial begin
      //            icode valA                    valE                   valP     rdata                   req we addr    wdata   err valM
      vecs[0] = '{4'h4, 64'hDEAD, 64'h10, 64'h0, 64'h0, 1, 1, 64'h10, 64'hDEAD, 0, 64'hDEAD};
      vecs[1] = '{4'h5, 64'h77, 64'h10, 64'h0, 64'hDEAD, 1, 0, 64'h10, 64'h0, 0, 64'hDEAD};
      vecs[2] = '{4'h8, 64'h5, 64'h3F8, 64'h123, 64'h0, 1, 1, 64'h3F8, 64'h123, 0, 64'h123};
      vecs[3] = '{4'h9, 64'h3F8, 64'h999, 64'h0, 64'hCAFE, 1, 0, 64'h3F8, 64'h0, 0, 64'hCAFE};
      vecs[4] = '{4'hB, 64'h400, 64'h0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 1, 64'hCAFE};
      vecs[5] = '{4'h6, 64'h1, 64'h2, 64'h3, 64'h0, 0, 0, 64'h0, 64'h0, 0, 64'hCAFE};
      vecs[6] = '{4'hA, 64'hBEEF, 64'h3FF, 64'h0, 64'h0, 1, 1, 64'h3FF, 64'hBEEF, 0, 64'hBEEF};
      vecs[7] = '{4'h5, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 1, 64'hBEEF};
      vecs[8] = '{4'hB, 64'h3FF, 64'h0, 64'h0, 64'h1234_5678_9ABC_DEF0, 1, 0, 64'h3FF, 64'h0, 0,
                  64'h1234_5678_9ABC_DEF0};
      vecs[9] = '{4'h0, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 0, 64'h1234_5678_9ABC_DEF0};

      rst = 1'b1; start = 1'b0; icode = '0; valA = '0; valE = '0; valP = '0;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_valM", valM, 64'h0);
      chk("rst_err", 64'(mem_err), 64'(0));
      chk("rst_req_valid", 64'(req_valid), 64'(0));
      chk("rst_req_addr", req_addr, 64'h0);

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Backpressure: five cycles without ready, stray starts ignored.
      begin
         int hs0;
         hs0 = hs_cnt;
         launch(4'h4, 64'h55, 64'h20, 64'h0);
         for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 64'(req_valid), 64'(1));
            chk("bp_addr", req_addr, 64'h20);
            chk("bp_wdata", req_wdata, 64'h55);
            chk("bp_busy", 64'(busy), 64'(1));
            if (c == 1) begin icode = 4'h6; start = 1'b1; end
            @(negedge clk);
            start = 1'b0;
         end
         req_ready = 1'b1;
         @(negedge clk);
         chk("bp_drop", 64'(req_valid), 64'(0));
         rsp_valid = 1'b1;
         @(negedge clk);
         req_ready = 1'b0; rsp_valid = 1'b0;
         chk("bp_done", 64'(done), 64'(1));
         chk("bp_valM", valM, 64'h55);
         chk("bp_one_hs", 64'(hs_cnt - hs0), 64'(1));
         @(negedge clk);
         @(negedge clk);
         chk("bp_no_queued", 64'(busy), 64'(0));
      end

      // Timeout: accepted read, never answered; done 9 cycles into the op.
      launch(4'h5, 64'h0, 64'h30, 64'h0);
      req_ready = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         chk("to_no_done", 64'(done), 64'(0));
         @(negedge clk);
         req_ready = 1'b0;
      end
      chk("to_done", 64'(done), 64'(1));
      chk("to_err", 64'(mem_err), 64'(1));
      chk("to_valM", valM, 64'h55);
      @(negedge clk);
      rsp_valid = 1'b1; rsp_rdata = 64'hBAD;
      @(negedge clk);
      rsp_valid = 1'b0;
      chk("stray_done", 64'(done), 64'(0));
      chk("stray_valM", valM, 64'h55);
      chk("stray_err", 64'(mem_err), 64'(1));

      // Response in the terminal-count cycle wins over the timeout.
      launch(4'h5, 64'h0, 64'h40, 64'h0);
      req_ready = 1'b1;
      rsp_rdata = 64'h4242;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         req_ready = 1'b0;
      end
      rsp_valid = 1'b1;
      @(negedge clk);
      rsp_valid = 1'b0;
      chk("win_done", 64'(done), 64'(1));
      chk("win_err", 64'(mem_err), 64'(0));
      chk("win_valM", valM, 64'h4242);
      @(negedge clk);

      // Reset during WAIT.
      launch(4'h5, 64'h0, 64'h50, 64'h0);
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_busy", 64'(busy), 64'(0));
      chk("mrst_done", 64'(done), 64'(0));
      chk("mrst_valM", valM, 64'h0);
      chk("mrst_req_valid", 64'(req_valid), 64'(0));
      chk("mrst_req_addr", req_addr, 64'h0);
      @(negedge clk);
      chk("mrst_no_done", 64'(done), 64'(0));
      run_vec('{4'h4, 64'h99, 64'h8, 64'h0, 64'h0, 1, 1, 64'h8, 64'h99, 0, 64'h99}, 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_req_initiator.md
# mem_req_initiator

Initiator side of the data-memory interface for the Y86-64 sequential core. It accepts a decoded memory-stage operation, that is icode, valA, valE and valP. It then issues a single valid/ready request to a multi-cycle data memory, waits for the response, and returns valM and mem_err with a one-cycle done pulse. It replaces direct array access from the memory stage, so the core can stall on busy while a slow or external memory responds.

## Interface
- ADDR_LIMIT, 1023: highest legal byte address. Any address above it is an error and no request is issued.
- TIMEOUT, 255: maximum number of cycles spent in REQ+WAIT before the operation is aborted with mem_err.
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  reset, synchronous and active-high
- start  input  1  one-cycle pulse launching an operation; ignored while busy
- icode  input  4  instruction code, sampled when start is accepted
- valA, valE, valP  input  64 each  operand values, sampled when start is accepted
- busy  output  1  high whenever the state is not IDLE
- done  output  1  one-cycle pulse marking the end of an operation
- valM  output  64  read data, or the written data for write operations
- mem_err  output  1  error flag for the last completed operation
- req_valid  output  1  request valid
- req_ready  input  1  memory accepts the request
- req_we  output  1  1 = write, 0 = read
- req_addr  output  64  request address
- req_wdata  output  64  write data
- rsp_valid  input  1  response strobe; returned for both reads and writes (write ack)
- rsp_rdata  input  64  read data, valid when rsp_valid is high

## Operation
- States are IDLE, REQ, WAIT and DONE.
- Decode happens on an accepted start, and all operands are latched at that point:
  - Writes:
    - 4 (rmmovq): addr=valE, data=valA
    - 8 (call): addr=valE, data=valP
    - A (pushq): addr=valE, data=valA
  - Reads:
    - 5 (mrmovq): addr=valE
    - 9 (ret): addr=valA
    - B (popq): addr=valA
  - Any other icode makes no access.
- IDLE with start:
  - No-access icode goes to DONE with mem_err=0 and valM unchanged.
  - Address > ADDR_LIMIT (unsigned 64-bit compare) goes to DONE with mem_err=1 and valM unchanged. No request is issued.
  - Otherwise go to REQ and drive req_valid=1 with req_we/addr/wdata from the latched values.
- REQ:
  - req_valid stays high and the request fields stay stable until req_valid&req_ready.
  - On that handshake, go to WAIT and drop req_valid.
  - rsp_valid is ignored in REQ.
- WAIT: on rsp_valid, go to DONE.
  - Read: valM = rsp_rdata.
  - Write: valM = the written data.
  - In both cases mem_err=0.
- Timeout:
  - The counter clears on an accepted start and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT, go to DONE with mem_err=1, valM unchanged and req_valid dropped.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- rsp_valid in IDLE or DONE, including a late response after a timeout, is ignored.
- valM and mem_err hold until the next operation completes.
- start while busy is dropped and is never queued.

## Timing
- Reset:
  - State is IDLE.
  - busy, done, mem_err, req_valid and req_we are 0.
  - valM, req_addr and req_wdata are 0.
  - The timeout counter is 0.
- rst asserted mid-operation aborts at that edge, with no done pulse. The memory sees req_valid drop and must tolerate the abandoned transaction.
- Start accepted at edge t:
  - No-access or address error: done is high in cycle t+1.
  - Memory access: REQ begins in cycle t+1. With a handshake in cycle h and rsp_valid in cycle w > h, done is high in cycle w+1.
  - Minimum latency is done in cycle t+3.
- busy rises in cycle t+1 and falls when the state re-enters IDLE, which is the cycle after done.
- rsp_valid in the same cycle as the timeout terminal count means the response wins: the operation completes normally with mem_err=0.
- The address check is against the latched address, so ADDR_LIMIT itself is legal.

## Test plan
- Write then read:
  - start icode=4, valE=0x10, valA=0xDEAD, with req_ready=1. Expect req_we=1, addr=0x10, wdata=0xDEAD; ack one cycle later. done in cycle t+3, valM=0xDEAD, mem_err=0.
  - Then icode=5, valE=0x10, with rsp_rdata=0xDEAD. Expect valM=0xDEAD.
- Stack ops:
  - icode=8, valE=0x3F8, valP=0x123. Expect wdata=0x123.
  - icode=9, valA=0x3F8. Expect addr=0x3F8.
  - icode=B with valA=0x400 (ADDR_LIMIT=1023). Expect done at t+1, mem_err=1, no req_valid.
- Backpressure:
  - Hold req_ready=0 for 5 cycles. Expect req_valid and fields stable, busy=1, start pulses ignored.
  - Then req_ready=1. Expect exactly one handshake.
- Timeout:
  - TIMEOUT=8 and rsp_valid never asserted. Expect done with mem_err=1 eight cycles after the accepted start.
  - A later stray rsp_valid leaves valM and mem_err unchanged.
- No-access: icode=6. Expect done at t+1, mem_err=0, valM unchanged, no request.
- Reset mid-WAIT: assert rst for one cycle. Expect IDLE, all outputs 0, no done pulse; a new start proceeds normally.
